multdiv_iterative: RTL and testbench

- Sequential 32-bit signed multiply/divide unit. It sits directly beside the execute stage of the 5-stage pipeline and is the unit that feeds the stage's mult/div result path.
- The execute stage issues a one-cycle start pulse with both operands.
- The unit iterates one bit per cycle and returns the low 32-bit product or the truncated quotient.
- It raises data_resultRDY for one cycle so the pipeline stall releases.

---
 rtl/multdiv_iterative.sv | 142 ++++++++++++++
 tb/tb_multdiv_iterative.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iterative.sv
// Sequential 32-bit signed multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, 33-cycle latency.
module multdiv_iterative (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [5:0]  count_r;
  logic [63:0] acc_r;
  logic [63:0] acc_s;
  logic [31:0] opnd_r;
  logic        neg_r;
  logic        b_zero_r;
  logic        div_ovf_r;

  logic        start_s;
  logic        busy_s;
  logic        iter_s;
  logic        finish_s;
  logic [32:0] sum_s;
  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] res_s;
  logic        exc_s;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    if (v[31]) begin
      abs32 = 32'd0 - v;
    end else begin
      abs32 = v;
    end
  endfunction

  assign start_s  = ctrl_MULT | ctrl_DIV;
  assign busy_s   = (state_r == MUL) || (state_r == DIV);
  assign iter_s   = busy_s && (count_r != 6'd32);
  assign finish_s = busy_s && (count_r == 6'd32);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a start pre-empts whatever is running, MULT over DIV.
  always_comb begin
    state_s = state_r;
    if (start_s) begin
      state_s = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state_r)
        IDLE:     state_s = IDLE;
        MUL, DIV: state_s = (count_r == 6'd32) ? DONE : state_r;
        DONE:     state_s = IDLE;
        default:  state_s = IDLE;
      endcase
    end
  end

  // One iteration step and the final sign/exception fix-up.
  always_comb begin
    sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    rem_sh_s = {acc_r[63:32], acc_r[31]};
    diff_s   = rem_sh_s - {1'b0, opnd_r};
    if (state_r == MUL) begin
      acc_s = {sum_s, acc_r[31:1]};
    end else if (!diff_s[32]) begin
      acc_s = {diff_s[31:0], acc_r[30:0], 1'b1};
    end else begin
      acc_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
    end

    prod_s = neg_r ? (64'd0 - acc_r) : acc_r;
    quo_s  = neg_r ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    if (state_r == MUL) begin
      res_s = prod_s[31:0];
      exc_s = !((&prod_s[63:31]) || !(|prod_s[63:31]));
    end else if (b_zero_r) begin
      res_s = 32'd0;
      exc_s = 1'b1;
    end else begin
      res_s = quo_s;
      exc_s = div_ovf_r;
    end
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r        <= 6'd0;
      acc_r          <= 64'd0;
      opnd_r         <= 32'd0;
      neg_r          <= 1'b0;
      b_zero_r       <= 1'b0;
      div_ovf_r      <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (start_s) begin
      // Multiply keeps |A| as the addend; divide keeps |B| as the divisor.
      count_r        <= 6'd0;
      opnd_r         <= ctrl_MULT ? abs32(data_operandA) : abs32(data_operandB);
      acc_r          <= {32'd0, ctrl_MULT ? abs32(data_operandB) : abs32(data_operandA)};
      neg_r          <= data_operandA[31] ^ data_operandB[31];
      b_zero_r       <= (data_operandB == 32'd0);
      div_ovf_r      <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      data_resultRDY <= 1'b0;
    end else if (iter_s) begin
      acc_r          <= acc_s;
      count_r        <= count_r + 6'd1;
      data_resultRDY <= 1'b0;
    end else if (finish_s) begin
      data_result    <= res_s;
      data_exception <= exc_s;
      data_resultRDY <= 1'b1;
    end else begin
      data_resultRDY <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multdiv_iterative.sv
// Self-checking bench for multdiv_iterative: directed and random operations
// checked against a plain-arithmetic reference model.
module tb_multdiv_iterative;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks;
  int failures;

  multdiv_iterative dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact 64-bit signed arithmetic.
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    longint q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0];
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       pick = 32'd0;
      1:       pick = 32'h8000_0000;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'($urandom_range(0, 40));
      4:       pick = 32'd0 - 32'($urandom_range(1, 40));
      default: pick = $urandom;
    endcase
  endfunction

  // Drive a one-cycle start; returns just after the start edge with operands scrambled.
  task automatic issue(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Observe 40 edges after the start edge; lat = edge index of first RDY (-1 if none).
  task automatic wait_rdy(output int lat, output int pulses, output logic [31:0] r, output logic e);
    lat    = -1;
    pulses = 0;
    r      = 32'd0;
    e      = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          r   = data_result;
          e   = data_exception;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (data_result !== 32'd0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=%h", data_result, 32'd0);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      failures++;
      $display("FAIL reset_exc got=%b exp=0", data_exception);
    end
    checks++;
    if (data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy got=%b exp=0", data_resultRDY);
    end
  endtask

  task automatic test_mul_directed();
    logic [31:0] va [3] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] vb [3] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] r, er;
    logic e, ee;
    int lat, pulses;
    for (int i = 0; i < 3; i++) begin
      model(1'b1, va[i], vb[i], er, ee);
      issue(1'b1, 1'b0, va[i], vb[i]);
      wait_rdy(lat, pulses, r, e);
      checks++;
      if (lat !== 33 || pulses !== 1) begin
        failures++;
        $display("FAIL mul_timing[%0d] lat=%0d pulses=%0d exp lat=33 pulses=1", i, lat, pulses);
      end
      checks++;
      if (r !== er) begin
        failures++;
        $display("FAIL mul_result[%0d] got=%h exp=%h", i, r, er);
      end
      if (i < 2) begin
        checks++;
        if (e !== ee) begin
          failures++;
          $display("FAIL mul_exc[%0d] got=%b exp=%b", i, e, ee);
        end
      end
    end
  endtask

  task automatic test_div_directed();
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
    logic [31:0] vb [4] = '{32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] r, er;
    logic e, ee;
    int lat, pulses;
    for (int i = 0; i < 4; i++) begin
      model(1'b0, va[i], vb[i], er, ee);
      issue(1'b0, 1'b1, va[i], vb[i]);
      wait_rdy(lat, pulses, r, e);
      checks++;
      if (lat !== 33 || pulses !== 1) begin
        failures++;
        $display("FAIL div_timing[%0d] lat=%0d pulses=%0d exp lat=33 pulses=1", i, lat, pulses);
      end
      checks++;
      if (r !== er || e !== ee) begin
        failures++;
        $display("FAIL div_result[%0d] got=%h/%b exp=%h/%b", i, r, e, er, ee);
      end
    end
    // Divide-by-zero result must hold with RDY low while idle.
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      checks++;
      if (data_resultRDY !== 1'b0 || data_result !== 32'd0 || data_exception !== 1'b1) begin
        failures++;
        $display("FAIL div0_hold[%0d] got rdy=%b res=%h exc=%b exp rdy=0 res=0 exc=1",
                 k, data_resultRDY, data_result, data_exception);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic e, ee;
    bit is_mul;
    int lat, pulses;
    for (int i = 0; i < 24; i++) begin
      a = pick();
      b = pick();
      is_mul = 1'($urandom_range(0, 1));
      model(is_mul, a, b, er, ee);
      issue(is_mul, !is_mul, a, b);
      wait_rdy(lat, pulses, r, e);
      checks++;
      if (lat !== 33 || pulses !== 1 || r !== er || e !== ee) begin
        failures++;
        $display("FAIL random[%0d] %s a=%h b=%h got lat=%0d n=%0d %h/%b exp lat=33 n=1 %h/%b",
                 i, is_mul ? "mul" : "div", a, b, lat, pulses, r, e, er, ee);
      end
    end
  endtask

  task automatic test_restart();
    logic [31:0] r;
    logic e;
    int lat, pulses;
    int early;
    early = 0;
    issue(1'b1, 1'b0, 32'd3, 32'd4);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) early++;
    end
    issue(1'b0, 1'b1, 32'd20, 32'd5);
    wait_rdy(lat, pulses, r, e);
    checks++;
    if (early !== 0 || lat !== 33 || pulses !== 1) begin
      failures++;
      $display("FAIL restart_timing early=%0d lat=%0d pulses=%0d exp 0/33/1", early, lat, pulses);
    end
    checks++;
    if (r !== 32'd4 || e !== 1'b0) begin
      failures++;
      $display("FAIL restart_result got=%h/%b exp=%h/0", r, e, 32'd4);
    end
    issue(1'b1, 1'b1, 32'd6, 32'd3);
    wait_rdy(lat, pulses, r, e);
    checks++;
    if (lat !== 33 || r !== 32'd18 || e !== 1'b0) begin
      failures++;
      $display("FAIL both_start got lat=%0d %h/%b exp lat=33 %h/0", lat, r, e, 32'd18);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] r, er;
    logic e, ee;
    int lat, pulses;
    int seen;
    seen = 0;
    issue(1'b1, 1'b0, 32'd1234, 32'd5678);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got res=%h exc=%b rdy=%b exp 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    @(posedge clock);
    #1;
    if (data_resultRDY === 1'b1) seen++;
    model(1'b0, 32'hFFFF_FF9C, 32'd9, er, ee);
    issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd9);
    wait_rdy(lat, pulses, r, e);
    checks++;
    if (seen !== 0 || lat !== 33 || pulses !== 1 || r !== er || e !== ee) begin
      failures++;
      $display("FAIL midop_restart seen=%0d lat=%0d n=%0d %h/%b exp 0/33/1 %h/%b",
               seen, lat, pulses, r, e, er, ee);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r, er1, er2;
    logic e, ee1, ee2;
    int lat, pulses;
    logic rdy33;
    model(1'b1, 32'hFFFF_FFFD, 32'd11, er1, ee1);
    model(1'b0, 32'd1000, 32'hFFFF_FFFD, er2, ee2);
    issue(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd11);
    repeat (33) @(posedge clock);
    #1;
    rdy33 = data_resultRDY;
    checks++;
    if (rdy33 !== 1'b1 || data_result !== er1 || data_exception !== ee1) begin
      failures++;
      $display("FAIL b2b_first got rdy=%b %h/%b exp rdy=1 %h/%b",
               rdy33, data_result, data_exception, er1, ee1);
    end
    issue(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFFD);
    wait_rdy(lat, pulses, r, e);
    checks++;
    if (lat !== 33 || pulses !== 1 || r !== er2 || e !== ee2) begin
      failures++;
      $display("FAIL b2b_second lat=%0d n=%0d %h/%b exp 33/1 %h/%b", lat, pulses, r, e, er2, ee2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_random();
    test_restart();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
